// File: rtl/rf_writeback_pkg.sv
// Shared types and constants for the register-file write-back front end.
package rf_writeback_pkg;

   localparam int REG_W = 5;
   localparam int XLEN  = 32;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam logic [REG_W-1:0] REG_SP   = 5'd2;
   localparam logic [XLEN-1:0]  SP_VAL   = 32'h2ffc;

   typedef struct packed {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } wb_req_t;

   // x0 and the hardwired stack pointer are never written and never tracked.
   function automatic logic is_dropped(logic [REG_W-1:0] rd, logic [REG_W-1:0] sp);
      return (rd == REG_ZERO) || (rd == sp);
   endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// Producer, decoder-query and RF write-port signals of the write-back front end.
// valid/ready: a result transfers on a rising edge where valid && ready; once
// valid is raised the producer holds rd/data stable until that edge.
interface rf_writeback_if;
   import rf_writeback_pkg::*;

   logic             alu_valid;
   logic             alu_ready;
   logic [REG_W-1:0] alu_rd;
   logic [XLEN-1:0]  alu_data;

   logic             mem_valid;
   logic             mem_ready;
   logic [REG_W-1:0] mem_rd;
   logic [XLEN-1:0]  mem_data;

   logic             issue_en;
   logic [REG_W-1:0] issue_rd;
   logic [REG_W-1:0] q_ra1;
   logic [REG_W-1:0] q_ra2;
   logic             busy1;
   logic             busy2;

   logic             rf_we;
   logic [REG_W-1:0] rf_wa;
   logic [XLEN-1:0]  rf_wd;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      input  issue_en, issue_rd, q_ra1, q_ra2,
      output alu_ready, mem_ready, busy1, busy2,
      output rf_we, rf_wa, rf_wd
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      output issue_en, issue_rd, q_ra1, q_ra2,
      input  alu_ready, mem_ready, busy1, busy2,
      input  rf_we, rf_wa, rf_wd
   );

endinterface

// File: rtl/rf_writeback_wb_fifo.sv
// Circular FIFO of write-back requests; an extra pointer bit separates full from empty.
module wb_fifo
   import rf_writeback_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t head,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

   assign head  = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/rf_writeback.sv
// Merges ALU and MEM/MDU results onto the single RF write port and keeps the
// pending-destination scoreboard that the decoder queries for hazards.
module rf_writeback
   import rf_writeback_pkg::*;
#(
   parameter int               DEPTH  = 4,
   parameter logic [REG_W-1:0] SP_REG = REG_SP
) (
   input  logic          clk,
   input  logic          rst,
   rf_writeback_if.slave wb
);

   localparam logic [31:0] SB_KEEP = ~((32'd1 << REG_ZERO) | (32'd1 << SP_REG));

   wb_req_t alu_req;
   wb_req_t mem_req;
   wb_req_t head;
   wb_req_t commit_req;
   logic    full;
   logic    empty;
   logic    push;
   logic    pop;
   logic    alu_acc;
   logic    commit_v;
   logic    commit_we;

   logic             rf_we_q;
   logic [REG_W-1:0] rf_wa_q;
   logic [XLEN-1:0]  rf_wd_q;
   logic [31:0]      sb;
   logic [31:0]      sb_set;
   logic [31:0]      sb_clr;

   assign alu_req = '{rd: wb.alu_rd, data: wb.alu_data};
   assign mem_req = '{rd: wb.mem_rd, data: wb.mem_data};

   assign wb.mem_ready = 1'b1;
   assign wb.alu_ready = !full;
   assign alu_acc      = wb.alu_valid && !full;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (alu_req),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // MEM always wins; a queued ALU result goes next; an ALU result skips the
   // FIFO only when nothing is queued ahead of it.
   always_comb begin
      push       = 1'b0;
      pop        = 1'b0;
      commit_v   = 1'b0;
      commit_req = alu_req;
      if (wb.mem_valid) begin
         commit_v   = 1'b1;
         commit_req = mem_req;
         push       = alu_acc;
      end else if (!empty) begin
         commit_v   = 1'b1;
         commit_req = head;
         pop        = 1'b1;
         push       = alu_acc;
      end else if (alu_acc) begin
         commit_v   = 1'b1;
         commit_req = alu_req;
      end
   end

   assign commit_we = commit_v && !is_dropped(commit_req.rd, SP_REG);

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q <= 1'b0;
         rf_wa_q <= '0;
         rf_wd_q <= '0;
      end else begin
         rf_we_q <= commit_we;
         if (commit_we) begin
            rf_wa_q <= commit_req.rd;
            rf_wd_q <= commit_req.data;
         end
      end
   end

   assign wb.rf_we = rf_we_q;
   assign wb.rf_wa = rf_wa_q;
   assign wb.rf_wd = rf_wd_q;

   // Set after clear so a newer producer issued in the commit cycle stays pending.
   assign sb_clr = rf_we_q     ? (32'd1 << rf_wa_q)     : 32'd0;
   assign sb_set = wb.issue_en ? (32'd1 << wb.issue_rd) : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) sb <= '0;
      else     sb <= ((sb & ~sb_clr) | sb_set) & SB_KEEP;
   end

   // The write landing now is forwarded by the RF, so it already reads as not busy.
   assign wb.busy1 = sb[wb.q_ra1] && !(rf_we_q && (rf_wa_q == wb.q_ra1));
   assign wb.busy2 = sb[wb.q_ra2] && !(rf_we_q && (rf_wa_q == wb.q_ra2));

endmodule
